// File: rtl/encryption_round_engine.sv
// encryption_round_engine
// Iterative AES-128 encryptor. One round of SubBytes/ShiftRows/MixColumns
// plus one key-expansion step is instantiated and reused for rounds 1..10.
// Byte 0 of the state lives in bits [127:120], column-major as in FIPS-197.

module encryption_round_engine (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] plaintext,
   input  logic [127:0] key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out,
   output logic         busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } fsm_t;

   // Forward S-box, entry 0 in the most significant byte.
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sub_byte(input logic [7:0] b);
      logic [10:0] base;
      // ~b reverses the index so entry 0 maps to the top byte of the table
      base = {~b, 3'b000};
      return SBOX_TABLE[base +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] r;
      r = 128'h0;
      for (int i = 0; i < 16; i++) begin
         r[8*i +: 8] = sub_byte(s[8*i +: 8]);
      end
      return r;
   endfunction

   // Row r of column c takes the byte from column (c + r) mod 4.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] r;
      r = 128'h0;
      for (int c = 0; c < 4; c++) begin
         for (int rw = 0; rw < 4; rw++) begin
            r[127 - 8*(rw + 4*c) -: 8] = s[127 - 8*(rw + 4*((c + rw) % 4)) -: 8];
         end
      end
      return r;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] r;
      logic [7:0]   a0, a1, a2, a3;
      r = 128'h0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127 - 32*c -: 8];
         a1 = s[119 - 32*c -: 8];
         a2 = s[111 - 32*c -: 8];
         a3 = s[103 - 32*c -: 8];
         r[127 - 32*c -: 32] = {
            xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
         };
      end
      return r;
   endfunction

   // One AES-128 key schedule step: four new words from the previous round key.
   function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] rot;
      logic [31:0] temp;
      logic [31:0] n0, n1, n2, n3;
      rot  = {k[23:0], k[31:24]};
      temp = {sub_byte(rot[31:24]), sub_byte(rot[23:16]),
              sub_byte(rot[15:8]),  sub_byte(rot[7:0])} ^ {rc, 24'h000000};
      n0 = k[127:96] ^ temp;
      n1 = k[95:64]  ^ n0;
      n2 = k[63:32]  ^ n1;
      n3 = k[31:0]   ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   function automatic logic [7:0] round_rcon(input logic [3:0] rnd);
      logic [7:0] rc;
      case (rnd)
         4'd1:    rc = 8'h01;
         4'd2:    rc = 8'h02;
         4'd3:    rc = 8'h04;
         4'd4:    rc = 8'h08;
         4'd5:    rc = 8'h10;
         4'd6:    rc = 8'h20;
         4'd7:    rc = 8'h40;
         4'd8:    rc = 8'h80;
         4'd9:    rc = 8'h1b;
         4'd10:   rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return rc;
   endfunction

   fsm_t         fsm;
   logic [127:0] state_reg;
   logic [127:0] rkey_reg;
   logic [3:0]   round;

   logic [127:0] next_key;
   logic [127:0] shifted;
   logic [127:0] round_result;

   // Single shared round datapath; the last round skips MixColumns.
   assign next_key     = key_expand(rkey_reg, round_rcon(round));
   assign shifted      = shift_rows(sub_bytes(state_reg));
   assign round_result = ((round == 4'd10) ? shifted : mix_columns(shifted)) ^ next_key;

   // Control FSM with registered handshake flags, state, round key and result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fsm       <= IDLE;
         state_reg <= 128'h0;
         rkey_reg  <= 128'h0;
         round     <= 4'd0;
         out       <= 128'h0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         case (fsm)
            IDLE: begin
               if (in_valid) begin
                  state_reg <= plaintext ^ key;
                  rkey_reg  <= key;
                  round     <= 4'd1;
                  busy      <= 1'b1;
                  in_ready  <= 1'b0;
                  fsm       <= ROUND;
               end else begin
                  in_ready  <= 1'b1;
               end
            end
            ROUND: begin
               state_reg <= round_result;
               rkey_reg  <= next_key;
               if (round == 4'd10) begin
                  // Counter parks at 0 so it only ever holds 1..10 while active.
                  round     <= 4'd0;
                  out       <= round_result;
                  out_valid <= 1'b1;
                  busy      <= 1'b0;
                  fsm       <= DONE;
               end else begin
                  round     <= round + 4'd1;
               end
            end
            DONE: begin
               // New work is only accepted from IDLE, never on the handoff edge.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  fsm       <= IDLE;
               end else begin
                  out_valid <= 1'b1;
               end
            end
            default: begin
               fsm       <= IDLE;
               round     <= 4'd0;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_encryption_round_engine.sv
// Directed testbench for encryption_round_engine using FIPS-197 vectors.

module tb_encryption_round_engine;

   logic         clk;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] plaintext;
   logic [127:0] key;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out;
   logic         busy;

   int pass_count;
   int check_count;

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_R0   = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [127:0] B_R1   = 128'ha49c7ff2689f352b6b5bea43026a5049;

   encryption_round_engine dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .plaintext (plaintext),
      .key       (key),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Offer one vector at the current negedge; returns at the negedge after the accept edge.
   task automatic start_txn(input logic [127:0] pt, input logic [127:0] k);
      plaintext = pt;
      key       = k;
      in_valid  = 1'b1;
      @(negedge clk);
      in_valid  = 1'b0;
   endtask

   // Wait (bounded) for out_valid; lat counts edges after the accept edge.
   task automatic wait_done(output int lat);
      lat = 0;
      while (!out_valid && lat < 30) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      plaintext = 128'h0;
      key       = 128'h0;
      repeat (2) @(negedge clk);
      check_count++;
      if (out !== 128'h0) $display("FAIL reset_out: got %h want %h", out, 128'h0);
      else pass_count++;
      check_count++;
      if ({out_valid, busy, in_ready} !== 3'b001)
         $display("FAIL reset_flags: got %b want %b", {out_valid, busy, in_ready}, 3'b001);
      else pass_count++;
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_fips_c1();
      int lat;
      out_ready = 1'b1;
      start_txn(C1_PT, C1_KEY);
      check_count++;
      if ({busy, in_ready} !== 2'b10)
         $display("FAIL c1_busy: got %b want %b", {busy, in_ready}, 2'b10);
      else pass_count++;
      wait_done(lat);
      check_count++;
      if (lat !== 10) $display("FAIL c1_latency: got %0d want %0d", lat, 10);
      else pass_count++;
      check_count++;
      if (out !== C1_CT) $display("FAIL c1_out: got %h want %h", out, C1_CT);
      else pass_count++;
      @(negedge clk);
      check_count++;
      if ({out_valid, in_ready} !== 2'b01)
         $display("FAIL c1_one_cycle: got %b want %b", {out_valid, in_ready}, 2'b01);
      else pass_count++;
      check_count++;
      if (out !== C1_CT) $display("FAIL c1_out_hold: got %h want %h", out, C1_CT);
      else pass_count++;
   endtask

   task automatic test_fips_b();
      int lat;
      out_ready = 1'b1;
      start_txn(B_PT, B_KEY);
      check_count++;
      if (dut.state_reg !== B_R0) $display("FAIL b_round0: got %h want %h", dut.state_reg, B_R0);
      else pass_count++;
      @(negedge clk);
      check_count++;
      if (dut.state_reg !== B_R1) $display("FAIL b_round1: got %h want %h", dut.state_reg, B_R1);
      else pass_count++;
      wait_done(lat);
      check_count++;
      if (out !== B_CT) $display("FAIL b_out: got %h want %h", out, B_CT);
      else pass_count++;
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      int lat;
      int bad_valid;
      int bad_out;
      int bad_ready;
      out_ready = 1'b0;
      start_txn(C1_PT, C1_KEY);
      wait_done(lat);
      bad_valid = 0;
      bad_out   = 0;
      bad_ready = 0;
      for (int i = 0; i < 20; i++) begin
         // A second vector offered while the result waits must be ignored.
         plaintext = B_PT;
         key       = B_KEY;
         in_valid  = (i >= 5);
         if (out_valid !== 1'b1) bad_valid++;
         if (out !== C1_CT) bad_out++;
         if (in_ready !== 1'b0 || busy !== 1'b0) bad_ready++;
         @(negedge clk);
      end
      check_count++;
      if (bad_valid !== 0) $display("FAIL bp_valid_hold: got %0d drops want %0d", bad_valid, 0);
      else pass_count++;
      check_count++;
      if (bad_out !== 0) $display("FAIL bp_out_hold: got %0d changes want %0d", bad_out, 0);
      else pass_count++;
      check_count++;
      if (bad_ready !== 0) $display("FAIL bp_ready_low: got %0d bad cycles want %0d", bad_ready, 0);
      else pass_count++;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check_count++;
      if ({out_valid, in_ready, busy} !== 3'b010)
         $display("FAIL bp_handoff: got %b want %b", {out_valid, in_ready, busy}, 3'b010);
      else pass_count++;
      check_count++;
      if (out !== C1_CT) $display("FAIL bp_out_after: got %h want %h", out, C1_CT);
      else pass_count++;
      @(negedge clk);
      check_count++;
      if (busy !== 1'b0) $display("FAIL bp_no_accept: got %b want %b", busy, 1'b0);
      else pass_count++;
   endtask

   task automatic test_disturb();
      int lat;
      int extra;
      out_ready = 1'b1;
      start_txn(C1_PT, C1_KEY);
      lat = 0;
      while (!out_valid && lat < 30) begin
         if (lat == 3) begin
            plaintext = B_PT;
            key       = B_KEY;
            in_valid  = 1'b1;
         end else begin
            in_valid  = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      in_valid = 1'b0;
      check_count++;
      if (out !== C1_CT) $display("FAIL dist_out: got %h want %h", out, C1_CT);
      else pass_count++;
      extra = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (out_valid || busy) extra++;
      end
      check_count++;
      if (extra !== 0) $display("FAIL dist_no_second: got %0d active cycles want %0d", extra, 0);
      else pass_count++;
   endtask

   task automatic test_back_to_back();
      logic [127:0] res [2];
      int           acc_cyc [2];
      int           n_res;
      int           n_acc;
      int           cyc;
      logic         prev_busy;
      res[0] = 128'h0;
      res[1] = 128'h0;
      acc_cyc[0] = 0;
      acc_cyc[1] = 0;
      n_res = 0;
      n_acc = 0;
      cyc = 0;
      prev_busy = busy;
      out_ready = 1'b1;
      plaintext = C1_PT;
      key       = C1_KEY;
      in_valid  = 1'b1;
      while (cyc < 40 && n_res < 2) begin
         @(negedge clk);
         cyc++;
         if (busy && !prev_busy && n_acc < 2) begin
            acc_cyc[n_acc] = cyc;
            n_acc++;
            if (n_acc == 2) in_valid = 1'b0;
         end
         prev_busy = busy;
         if (out_valid && n_res < 2) begin
            res[n_res] = out;
            n_res++;
            plaintext  = B_PT;
            key        = B_KEY;
         end
      end
      in_valid = 1'b0;
      check_count++;
      if (n_res !== 2) $display("FAIL b2b_count: got %0d want %0d", n_res, 2);
      else pass_count++;
      check_count++;
      if (res[0] !== C1_CT) $display("FAIL b2b_first: got %h want %h", res[0], C1_CT);
      else pass_count++;
      check_count++;
      if (res[1] !== B_CT) $display("FAIL b2b_second: got %h want %h", res[1], B_CT);
      else pass_count++;
      check_count++;
      if (acc_cyc[1] - acc_cyc[0] !== 12)
         $display("FAIL b2b_period: got %0d want %0d", acc_cyc[1] - acc_cyc[0], 12);
      else pass_count++;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int lat;
      int extra;
      out_ready = 1'b1;
      start_txn(C1_PT, C1_KEY);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      #1;
      check_count++;
      if ({out_valid, busy, in_ready} !== 3'b001)
         $display("FAIL rst_mid_flags: got %b want %b", {out_valid, busy, in_ready}, 3'b001);
      else pass_count++;
      check_count++;
      if (out !== 128'h0) $display("FAIL rst_mid_out: got %h want %h", out, 128'h0);
      else pass_count++;
      @(negedge clk);
      reset = 1'b0;
      extra = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (out_valid || busy || !in_ready) extra++;
      end
      check_count++;
      if (extra !== 0) $display("FAIL rst_mid_quiet: got %0d active cycles want %0d", extra, 0);
      else pass_count++;
      start_txn(C1_PT, C1_KEY);
      wait_done(lat);
      check_count++;
      if (lat !== 10) $display("FAIL rst_rerun_latency: got %0d want %0d", lat, 10);
      else pass_count++;
      check_count++;
      if (out !== C1_CT) $display("FAIL rst_rerun_out: got %h want %h", out, C1_CT);
      else pass_count++;
      @(negedge clk);
   endtask

   initial begin
      pass_count  = 0;
      check_count = 0;
      test_reset();
      test_fips_c1();
      test_fips_b();
      test_backpressure();
      test_disturb();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
